nios2_fp_cpu_ocimem_arbiter: RTL and testbench
==============================================

// Module: nios2_fp_cpu_ocimem_arbiter
// PURPOSE
//  Sequences and arbitrates single-port accesses to the CPU's on-chip debug
//  memory (OCI RAM) between two requesters: the JTAG debug host (sysclk-side
//  take_action_ocimem_* strobes) and the CPU's debug-slave bus.
//  Owns a JTAG address register that auto-increments, the read-data holding
//  register returned to the host (MonDReg), and the RAM control/timing.
// PARAMETERS
//  ADDR_W  8   OCI RAM word-address width; 2**ADDR_W words
//  DATA_W  32  data width
//  RD_LAT  1   RAM read latency in cycles, address to ram_rdata valid (>=1)
// PORTS
//  clk            in  1       system clock; everything is on this single clock
//  reset_n        in  1       asynchronous, active-low reset
//  jtag_addr_ld   in  1       pulse: load jtag_addr_in into JTAG address register
//  jtag_addr_in   in  ADDR_W  new JTAG word address
//  jtag_go        in  1       pulse: request one JTAG access at current address
//  jtag_wr        in  1       with jtag_go: 1=write, 0=read
//  jtag_wdata     in  DATA_W  with jtag_go: write data
//  jtag_rdata     out DATA_W  MonDReg: last JTAG read data (holds)
//  jtag_done      out 1       1-cycle pulse: JTAG access complete
//  jtag_overrun   out 1       sticky: jtag_go dropped (already pending/busy)
//  jtag_addr      out ADDR_W  current JTAG address register
//  cpu_req        in  1       CPU access request; held until waitrequest low
//  cpu_we         in  1       1=write, 0=read; stable while cpu_req
//  cpu_addr       in  ADDR_W  CPU word address; stable while cpu_req
//  cpu_wdata      in  DATA_W  CPU write data
//  cpu_rdata      out DATA_W  CPU read data; valid while waitrequest low
//  cpu_waitrequest out 1      stall
//  ram_addr       out ADDR_W  RAM address
//  ram_we         out 1       RAM write enable
//  ram_wdata      out DATA_W  RAM write data
//  ram_rdata      in  DATA_W  RAM read data
// BEHAVIOUR
//  Reset (async): state IDLE; jtag_addr 0; jtag_rdata 0; cpu_rdata 0;
//   ram_addr 0; ram_we 0; ram_wdata 0; jtag_done 0; jtag_overrun 0.
//   Pending JTAG flag cleared. last_grant=CPU, so JTAG wins the first tie.
//  JTAG capture: jtag_go with no JTAG pending and no JTAG access in flight
//   sets pending and latches jtag_wr/jtag_wdata. Otherwise the go is dropped
//   and jtag_overrun is set.
//  jtag_overrun clears only on jtag_addr_ld.
//  FSM IDLE -> ACCESS -> (read: WAIT x RD_LAT) -> DONE -> IDLE.
//  IDLE: grant if pending or cpu_req. If both request, grant the requester
//   not in last_grant (alternating). In the same edge, load ram_addr and
//   ram_wdata, set owner and last_grant, and clear JTAG pending.
//  ACCESS (1 cycle): ram_addr valid; ram_we=1 only in this cycle, for writes.
//  WAIT: ram_addr held. On the edge leaving the last WAIT cycle, latch
//   ram_rdata into jtag_rdata (owner JTAG) or cpu_rdata (owner CPU).
//  DONE (1 cycle): owner CPU -> cpu_waitrequest=0. Owner JTAG -> jtag_done=1,
//   and jtag_addr increments mod 2**ADDR_W (0xFF -> 0x00).
//  Latency, req seen in IDLE at cycle 0: write DONE at cycle 2;
//   read DONE at cycle 2+RD_LAT.
//  cpu_waitrequest = cpu_req & ~(state==DONE & owner==CPU). Combinational,
//   so it is 1 during reset if cpu_req is high.
//  jtag_addr_ld in the same cycle as a JTAG DONE: the load wins, no increment.
//   The in-flight access keeps its latched ram_addr.
//  No back-to-back grant: IDLE always lasts at least 1 cycle between accesses.
//  Reset mid-access aborts it: no done pulse, and the pending request is lost.
// TESTING
//  1 Load addr 0x10, go write 0xDEADBEEF -> ram_we=1 exactly 1 cycle at addr
//    0x10; jtag_done 2 cycles after go is seen in IDLE; jtag_addr=0x11.
//  2 Load 0x10, go read (RAM[0x10]=0xDEADBEEF, RD_LAT=1) -> jtag_done at cycle 3;
//    jtag_rdata=0xDEADBEEF; addr=0x11.
//  3 cpu_req and jtag pending raised in the same cycle, then both again -> JTAG
//    is granted first, then CPU; waitrequest stays high until the CPU's DONE.
//  4 jtag_addr 0xFF, go write -> jtag_addr wraps to 0x00; a second go while
//    busy -> jtag_overrun=1; next jtag_addr_ld clears it.
//  5 reset_n low during WAIT -> all outputs at reset values at once;
//    no jtag_done; after release, the FSM is IDLE.
//  6 jtag_addr_ld 0x40 in the JTAG DONE cycle -> jtag_addr=0x40, not incremented.

Source files
------------

// File: rtl/nios2_fp_cpu_ocimem_arbiter.sv
// nios2_fp_cpu_ocimem_arbiter: sequences single-port OCI RAM accesses
// shared between the JTAG debug host and the CPU debug-slave port.
module nios2_fp_cpu_ocimem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              jtag_addr_ld,
   input  logic [ADDR_W-1:0] jtag_addr_in,
   input  logic              jtag_go,
   input  logic              jtag_wr,
   input  logic [DATA_W-1:0] jtag_wdata,
   output logic [DATA_W-1:0] jtag_rdata,
   output logic              jtag_done,
   output logic              jtag_overrun,
   output logic [ADDR_W-1:0] jtag_addr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t state, state_n;

   logic              pend;
   logic              pend_wr;
   logic [DATA_W-1:0] pend_wdata;
   logic              own_jtag;
   logic              last_jtag;
   logic              op_wr;
   logic [CNT_W-1:0]  cnt;

   logic              jtag_busy;
   logic              go_ok;
   logic              go_drop;
   logic              jtag_req;
   logic              grant;
   logic              pick_jtag;
   logic              j_wr;
   logic [DATA_W-1:0] j_wdata;
   logic              last_wait;
   logic              done_jtag;
   logic              done_cpu;

   assign jtag_busy = (state != IDLE) & own_jtag;
   assign go_ok     = jtag_go & ~pend & ~jtag_busy;
   assign go_drop   = jtag_go & ~go_ok;

   // An accepted go competes in the same IDLE cycle it arrives in.
   assign jtag_req  = pend | go_ok;
   assign j_wr      = pend ? pend_wr : jtag_wr;
   assign j_wdata   = pend ? pend_wdata : jtag_wdata;

   assign grant     = (state == IDLE) & (jtag_req | cpu_req);
   assign pick_jtag = jtag_req & (~cpu_req | ~last_jtag);

   assign last_wait = (state == WAIT) & (cnt == CNT_W'(RD_LAT - 1));
   assign done_jtag = (state == DONE) & own_jtag;
   assign done_cpu  = (state == DONE) & ~own_jtag;

   assign jtag_done       = done_jtag;
   assign cpu_waitrequest = cpu_req & ~done_cpu;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (grant) state_n = ACCESS;
         end
         ACCESS: begin
            state_n = op_wr ? DONE : WAIT;
         end
         WAIT: begin
            if (last_wait) state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         own_jtag  <= 1'b0;
         last_jtag <= 1'b0;
         op_wr     <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         if (grant) begin
            own_jtag  <= pick_jtag;
            last_jtag <= pick_jtag;
            ram_addr  <= pick_jtag ? jtag_addr : cpu_addr;
            ram_wdata <= pick_jtag ? j_wdata : cpu_wdata;
            op_wr     <= pick_jtag ? j_wr : cpu_we;
            ram_we    <= pick_jtag ? j_wr : cpu_we;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend       <= 1'b0;
         pend_wr    <= 1'b0;
         pend_wdata <= '0;
      end else if (grant & pick_jtag) begin
         pend <= 1'b0;
      end else if (go_ok) begin
         pend       <= 1'b1;
         pend_wr    <= jtag_wr;
         pend_wdata <= jtag_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (state == ACCESS) begin
         cnt <= '0;
      end else if (state == WAIT) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jtag_rdata <= '0;
         cpu_rdata  <= '0;
      end else if (last_wait) begin
         if (own_jtag) begin
            jtag_rdata <= ram_rdata;
         end else begin
            cpu_rdata <= ram_rdata;
         end
      end
   end

   // A host load beats the post-access increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jtag_addr <= '0;
      end else if (jtag_addr_ld) begin
         jtag_addr <= jtag_addr_in;
      end else if (done_jtag) begin
         jtag_addr <= jtag_addr + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jtag_overrun <= 1'b0;
      end else if (go_drop) begin
         jtag_overrun <= 1'b1;
      end else if (jtag_addr_ld) begin
         jtag_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nios2_fp_cpu_ocimem_arbiter.sv
// tb_nios2_fp_cpu_ocimem_arbiter: directed and randomized checks of the
// OCI RAM arbiter against a transaction-level memory/latency model.
module tb_nios2_fp_cpu_ocimem_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int RD_LAT = 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          jtag_addr_ld;
   logic [AW-1:0] jtag_addr_in;
   logic          jtag_go;
   logic          jtag_wr;
   logic [DW-1:0] jtag_wdata;
   logic [DW-1:0] jtag_rdata;
   logic          jtag_done;
   logic          jtag_overrun;
   logic [AW-1:0] jtag_addr;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_waitrequest;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   always #5 clk = ~clk;

   nios2_fp_cpu_ocimem_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .jtag_addr_ld(jtag_addr_ld),
      .jtag_addr_in(jtag_addr_in),
      .jtag_go(jtag_go),
      .jtag_wr(jtag_wr),
      .jtag_wdata(jtag_wdata),
      .jtag_rdata(jtag_rdata),
      .jtag_done(jtag_done),
      .jtag_overrun(jtag_overrun),
      .jtag_addr(jtag_addr),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .cpu_waitrequest(cpu_waitrequest),
      .ram_addr(ram_addr),
      .ram_we(ram_we),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // RAM with RD_LAT cycles from address to data
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign ram_rdata = rd_pipe[RD_LAT-1];

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [256];
   logic [AW-1:0] ref_jaddr;
   logic          ref_last_jtag;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   function automatic int acc_lat(input logic wr);
      return wr ? 2 : 2 + RD_LAT;
   endfunction

   task automatic clear_inputs();
      jtag_addr_ld = 1'b0;
      jtag_addr_in = '0;
      jtag_go = 1'b0;
      jtag_wr = 1'b0;
      jtag_wdata = '0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      ref_jaddr = '0;
      ref_last_jtag = 1'b0;
   endtask

   task automatic load_addr(input logic [AW-1:0] a);
      step();
      jtag_addr_ld = 1'b1;
      jtag_addr_in = a;
      step();
      jtag_addr_ld = 1'b0;
      probe();
      ref_jaddr = a;
   endtask

   // Drives one JTAG go and/or one CPU request raised in cycle 0 and
   // records the cycle each completes in.
   task automatic run_access(
      input  bit            do_j,
      input  logic          jwr,
      input  logic [DW-1:0] jwd,
      input  bit            do_c,
      input  logic          cwr,
      input  logic [AW-1:0] caddr,
      input  logic [DW-1:0] cwd,
      output int            jlat,
      output int            clat,
      output logic [DW-1:0] jrd,
      output logic [DW-1:0] crd,
      output int            we_n,
      output logic [AW-1:0] we_addr,
      output logic [DW-1:0] we_data,
      output int            jdn
   );
      jlat = -1;
      clat = -1;
      jrd = '0;
      crd = '0;
      we_n = 0;
      we_addr = '0;
      we_data = '0;
      jdn = 0;
      step();
      jtag_go = do_j;
      jtag_wr = jwr;
      jtag_wdata = jwd;
      cpu_req = do_c;
      cpu_we = cwr;
      cpu_addr = caddr;
      cpu_wdata = cwd;
      for (int c = 0; c < 30; c++) begin
         probe();
         if (ram_we) begin
            we_n++;
            we_addr = ram_addr;
            we_data = ram_wdata;
         end
         if (jtag_done) begin
            jdn++;
            if (jlat < 0) begin
               jlat = c;
               jrd = jtag_rdata;
            end
         end
         if (do_c && clat < 0 && !cpu_waitrequest) begin
            clat = c;
            crd = cpu_rdata;
         end
         if ((!do_j || jlat >= 0) && (!do_c || clat >= 0)) break;
         step();
         jtag_go = 1'b0;
         if (clat >= 0) cpu_req = 1'b0;
      end
      step();
      jtag_go = 1'b0;
      cpu_req = 1'b0;
      probe();
      if (jtag_done) jdn++;
   endtask

   // Transaction-level prediction: who goes first, when each finishes,
   // and what memory holds afterwards.
   task automatic model_apply(
      input  bit            do_j,
      input  logic          jwr,
      input  logic [DW-1:0] jwd,
      input  bit            do_c,
      input  logic          cwr,
      input  logic [AW-1:0] caddr,
      input  logic [DW-1:0] cwd,
      output int            ejlat,
      output int            eclat,
      output logic [DW-1:0] ejrd,
      output logic [DW-1:0] ecrd
   );
      bit jf;
      jf = do_j && (!do_c || !ref_last_jtag);
      ejlat = -1;
      eclat = -1;
      ejrd = '0;
      ecrd = '0;
      if (do_j && do_c) begin
         if (jf) begin
            ejlat = acc_lat(jwr);
            eclat = ejlat + 1 + acc_lat(cwr);
         end else begin
            eclat = acc_lat(cwr);
            ejlat = eclat + 1 + acc_lat(jwr);
         end
      end else if (do_j) begin
         ejlat = acc_lat(jwr);
      end else if (do_c) begin
         eclat = acc_lat(cwr);
      end
      for (int k = 0; k < 2; k++) begin
         if ((k == 0) == jf) begin
            if (do_j) begin
               if (jwr) ref_mem[ref_jaddr] = jwd;
               else ejrd = ref_mem[ref_jaddr];
               ref_jaddr = ref_jaddr + 8'd1;
               ref_last_jtag = 1'b1;
            end
         end else begin
            if (do_c) begin
               if (cwr) ref_mem[caddr] = cwd;
               else ecrd = ref_mem[caddr];
               ref_last_jtag = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      cpu_req = 1'b1;
      #2;
      checks++;
      if (cpu_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL reset_waitreq: got %b expected 1", cpu_waitrequest);
      end
      checks++;
      if ({jtag_done, jtag_overrun, ram_we} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000",
                  {jtag_done, jtag_overrun, ram_we});
      end
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if ({jtag_addr, ram_addr} !== 16'h0000) begin
         failures++;
         $display("FAIL reset_addr: got %h expected 0000",
                  {jtag_addr, ram_addr});
      end
      checks++;
      if ({jtag_rdata, cpu_rdata, ram_wdata} !== 96'h0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0",
                  {jtag_rdata, cpu_rdata, ram_wdata});
      end
      checks++;
      if (cpu_waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL reset_waitreq_idle: got %b expected 0",
                  cpu_waitrequest);
      end
      ref_jaddr = '0;
      ref_last_jtag = 1'b0;
   endtask

   task automatic test_jtag_write();
      int jl, cl, wn, jd, ej, ec;
      logic [DW-1:0] jr, cr, wd, er, ecr;
      logic [AW-1:0] wa;
      load_addr(8'h10);
      run_access(1, 1'b1, 32'hDEADBEEF, 0, 1'b0, '0, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b1, 32'hDEADBEEF, 0, 1'b0, '0, '0, ej, ec, er, ecr);
      checks++;
      if (jl !== 2) begin
         failures++;
         $display("FAIL jw_latency: got %0d expected 2", jl);
      end
      checks++;
      if (wn !== 1 || wa !== 8'h10 || wd !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL jw_ram: got we=%0d addr=%h data=%h expected 1 10 deadbeef",
                  wn, wa, wd);
      end
      checks++;
      if (jtag_addr !== 8'h11) begin
         failures++;
         $display("FAIL jw_addr_inc: got %h expected 11", jtag_addr);
      end
   endtask

   task automatic test_jtag_read();
      int jl, cl, wn, jd, ej, ec;
      logic [DW-1:0] jr, cr, wd, er, ecr;
      logic [AW-1:0] wa;
      load_addr(8'h10);
      run_access(1, 1'b0, '0, 0, 1'b0, '0, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b0, '0, 0, 1'b0, '0, '0, ej, ec, er, ecr);
      checks++;
      if (jl !== 3) begin
         failures++;
         $display("FAIL jr_latency: got %0d expected 3", jl);
      end
      checks++;
      if (jr !== 32'hDEADBEEF || wn !== 0) begin
         failures++;
         $display("FAIL jr_data: got %h we=%0d expected deadbeef we=0",
                  jr, wn);
      end
      checks++;
      if (jtag_addr !== 8'h11) begin
         failures++;
         $display("FAIL jr_addr_inc: got %h expected 11", jtag_addr);
      end
   endtask

   task automatic test_arbitration();
      int jl, cl, wn, jd, ej, ec;
      logic [DW-1:0] jr, cr, wd, er, ecr;
      logic [AW-1:0] wa;
      do_reset();
      // round 1: JTAG wins the first tie after reset
      run_access(1, 1'b1, 32'h11110000, 1, 1'b1, 8'h30, 32'h30303030,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b1, 32'h11110000, 1, 1'b1, 8'h30, 32'h30303030,
                  ej, ec, er, ecr);
      checks++;
      if (jl !== 2 || cl !== 5) begin
         failures++;
         $display("FAIL arb_r1: got j=%0d c=%0d expected j=2 c=5", jl, cl);
      end
      // round 2: CPU had the last grant, so JTAG wins again
      run_access(1, 1'b1, 32'h22220000, 1, 1'b0, 8'h30, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b1, 32'h22220000, 1, 1'b0, 8'h30, '0,
                  ej, ec, er, ecr);
      checks++;
      if (jl !== ej || cl !== ec || cr !== 32'h30303030) begin
         failures++;
         $display("FAIL arb_r2: got j=%0d c=%0d rd=%h expected j=%0d c=%0d rd=30303030",
                  jl, cl, cr, ej, ec);
      end
      // round 3: after a JTAG-only access the CPU wins the tie
      load_addr(8'h00);
      run_access(1, 1'b0, '0, 0, 1'b0, '0, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b0, '0, 0, 1'b0, '0, '0, ej, ec, er, ecr);
      run_access(1, 1'b0, '0, 1, 1'b0, 8'h30, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b0, '0, 1, 1'b0, 8'h30, '0, ej, ec, er, ecr);
      checks++;
      if (cl !== 3 || jl !== 7) begin
         failures++;
         $display("FAIL arb_r3: got j=%0d c=%0d expected j=7 c=3", jl, cl);
      end
      checks++;
      if (jr !== 32'h22220000) begin
         failures++;
         $display("FAIL arb_r3_data: got %h expected 22220000", jr);
      end
   endtask

   task automatic test_wrap_overrun();
      int jl, cl, wn, jd, ej, ec, extra;
      logic [DW-1:0] jr, cr, wd, er, ecr;
      logic [AW-1:0] wa;
      load_addr(8'hFF);
      run_access(1, 1'b1, 32'h12345678, 0, 1'b0, '0, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(1, 1'b1, 32'h12345678, 0, 1'b0, '0, '0, ej, ec, er, ecr);
      checks++;
      if (jtag_addr !== 8'h00 || wa !== 8'hFF) begin
         failures++;
         $display("FAIL wrap: got addr=%h ram=%h expected 00 ff", jtag_addr, wa);
      end
      step();
      jtag_go = 1'b1;
      jtag_wr = 1'b1;
      jtag_wdata = 32'hA5A50000;
      probe();
      step();
      jtag_wdata = 32'h0BAD0BAD;
      probe();
      step();
      jtag_go = 1'b0;
      probe();
      checks++;
      if (jtag_done !== 1'b1 || jtag_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set: got done=%b ovr=%b expected 1 1",
                  jtag_done, jtag_overrun);
      end
      extra = 0;
      repeat (5) begin
         step();
         probe();
         if (jtag_done) extra++;
      end
      ref_mem[0] = 32'hA5A50000;
      ref_jaddr = 8'h01;
      ref_last_jtag = 1'b1;
      checks++;
      if (extra !== 0 || jtag_addr !== 8'h01 || jtag_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_drop: got extra=%0d addr=%h ovr=%b expected 0 01 1",
                  extra, jtag_addr, jtag_overrun);
      end
      load_addr(8'h10);
      checks++;
      if (jtag_overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear: got %b expected 0", jtag_overrun);
      end
   endtask

   task automatic test_reset_abort();
      int jl, cl, wn, jd, ej, ec;
      logic [DW-1:0] jr, cr, wd, er, ecr;
      logic [AW-1:0] wa;
      step();
      jtag_go = 1'b1;
      jtag_wr = 1'b0;
      probe();
      step();
      jtag_go = 1'b0;
      probe();
      checks++;
      if (ram_addr !== 8'h10) begin
         failures++;
         $display("FAIL abort_access_addr: got %h expected 10", ram_addr);
      end
      step();
      cpu_req = 1'b1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({jtag_addr, ram_addr, jtag_done, jtag_overrun, ram_we} !== 19'h0) begin
         failures++;
         $display("FAIL abort_ctrl: got %h expected 0",
                  {jtag_addr, ram_addr, jtag_done, jtag_overrun, ram_we});
      end
      checks++;
      if ({jtag_rdata, cpu_rdata, ram_wdata} !== 96'h0 || cpu_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL abort_data: got %h wr=%b expected 0 wr=1",
                  {jtag_rdata, cpu_rdata, ram_wdata}, cpu_waitrequest);
      end
      jd = 0;
      repeat (3) begin
         probe();
         if (jtag_done) jd++;
         step();
      end
      cpu_req = 1'b0;
      probe();
      reset_n = 1'b1;
      ref_jaddr = '0;
      ref_last_jtag = 1'b0;
      run_access(0, 1'b0, '0, 1, 1'b1, 8'h11, 32'h0000CAFE,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(0, 1'b0, '0, 1, 1'b1, 8'h11, 32'h0000CAFE, ej, ec, er, ecr);
      checks++;
      if (cl !== 2 || jd !== 0) begin
         failures++;
         $display("FAIL abort_idle: got c=%0d dones=%0d expected 2 0", cl, jd);
      end
   endtask

   task automatic test_ld_in_done();
      int jl, cl, wn, jd, ej, ec;
      logic [DW-1:0] jr, cr, wd, er, ecr;
      logic [AW-1:0] wa;
      load_addr(8'h20);
      step();
      jtag_go = 1'b1;
      jtag_wr = 1'b1;
      jtag_wdata = 32'hCAFEF00D;
      probe();
      step();
      jtag_go = 1'b0;
      probe();
      step();
      jtag_addr_ld = 1'b1;
      jtag_addr_in = 8'h40;
      probe();
      checks++;
      if (jtag_done !== 1'b1) begin
         failures++;
         $display("FAIL ld_done_pulse: got %b expected 1", jtag_done);
      end
      step();
      jtag_addr_ld = 1'b0;
      probe();
      checks++;
      if (jtag_addr !== 8'h40) begin
         failures++;
         $display("FAIL ld_wins: got %h expected 40", jtag_addr);
      end
      ref_mem[8'h20] = 32'hCAFEF00D;
      ref_jaddr = 8'h40;
      ref_last_jtag = 1'b1;
      run_access(0, 1'b0, '0, 1, 1'b0, 8'h20, '0,
                 jl, cl, jr, cr, wn, wa, wd, jd);
      model_apply(0, 1'b0, '0, 1, 1'b0, 8'h20, '0, ej, ec, er, ecr);
      checks++;
      if (cr !== 32'hCAFEF00D || cl !== 3) begin
         failures++;
         $display("FAIL ld_inflight_addr: got %h c=%0d expected cafef00d c=3",
                  cr, cl);
      end
   endtask

   task automatic test_random();
      int jl, cl, wn, jd, ej, ec, kind;
      logic [DW-1:0] jr, cr, wd, er, ecr, jwd, cwd;
      logic [AW-1:0] wa, caddr;
      logic jwr, cwr;
      bit dj, dc;
      for (int a = 0; a < 16; a++) begin
         caddr = 8'h80 + 8'(a);
         cwd = $urandom;
         run_access(0, 1'b0, '0, 1, 1'b1, caddr, cwd,
                    jl, cl, jr, cr, wn, wa, wd, jd);
         model_apply(0, 1'b0, '0, 1, 1'b1, caddr, cwd, ej, ec, er, ecr);
         checks++;
         if (cl !== ec || wa !== caddr || wd !== cwd) begin
            failures++;
            $display("FAIL rnd_init: got c=%0d a=%h d=%h expected c=%0d a=%h d=%h",
                     cl, wa, wd, ec, caddr, cwd);
         end
      end
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 2);
         dj = (kind != 1);
         dc = (kind != 0);
         jwr = 1'($urandom_range(0, 1));
         cwr = 1'($urandom_range(0, 1));
         jwd = $urandom;
         cwd = $urandom;
         caddr = 8'h80 + 8'($urandom_range(0, 15));
         if (dj) load_addr(8'h80 + 8'($urandom_range(0, 15)));
         run_access(dj, jwr, jwd, dc, cwr, caddr, cwd,
                    jl, cl, jr, cr, wn, wa, wd, jd);
         model_apply(dj, jwr, jwd, dc, cwr, caddr, cwd, ej, ec, er, ecr);
         checks++;
         if (jl !== ej || cl !== ec) begin
            failures++;
            $display("FAIL rnd_latency it=%0d: got j=%0d c=%0d expected j=%0d c=%0d",
                     it, jl, cl, ej, ec);
         end
         checks++;
         if (dj && !jwr && jr !== er) begin
            failures++;
            $display("FAIL rnd_jtag_rdata it=%0d: got %h expected %h", it, jr, er);
         end
         checks++;
         if (dc && !cwr && cr !== ecr) begin
            failures++;
            $display("FAIL rnd_cpu_rdata it=%0d: got %h expected %h", it, cr, ecr);
         end
         checks++;
         if (jtag_addr !== ref_jaddr) begin
            failures++;
            $display("FAIL rnd_jtag_addr it=%0d: got %h expected %h",
                     it, jtag_addr, ref_jaddr);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_jtag_write();
      test_jtag_read();
      test_arbitration();
      test_wrap_overrun();
      test_reset_abort();
      test_ld_in_done();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
